// File: rtl/main_ram_arbiter_if.sv
// Requester-side access port of the main RAM arbiter: one request/acknowledge
// channel carrying word/byte reads and writes.
`timescale 1ns/1ps

interface main_ram_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/main_ram_arbiter.sv
// Two-port (CPU, DMA) arbiter and sequencer in front of the 64K x 16 main RAM.
// One access at a time: IDLE -> ACCESS -> (CAPTURE) -> DONE -> IDLE.
`timescale 1ns/1ps

module main_ram_arbiter #(
    parameter bit ARB_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    main_ram_arbiter_if.slave       cpu,
    main_ram_arbiter_if.slave       dma,
    output logic                    ram_chipselect,
    output logic                    ram_write,
    output logic [15:0]             ram_address,
    output logic [1:0]              ram_byteenable,
    output logic [15:0]             ram_writedata,
    input  logic [15:0]             ram_readdata,
    output logic                    ram_clken,
    output logic                    ram_reset_req,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    typedef enum logic {PORT_CPU = 1'b0, PORT_DMA = 1'b1} port_t;

    state_t      state, state_next;
    port_t       grant, last_grant, winner;
    logic        any_req;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [1:0]  sel_be;
    logic [15:0] sel_wdata;
    logic [15:0] cpu_rdata_q, dma_rdata_q;

    assign any_req       = cpu.req | dma.req;
    assign ram_clken     = 1'b1;
    assign ram_reset_req = reset;
    assign busy          = (state != IDLE);
    assign cpu.rdata     = cpu_rdata_q;
    assign dma.rdata     = dma_rdata_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        winner     = dma.req ? PORT_DMA : PORT_CPU;
        cpu.ack    = 1'b0;
        dma.ack    = 1'b0;

        // A tie goes to the CPU in fixed mode, otherwise to whoever did not win last.
        if (cpu.req && dma.req)
            winner = ARB_MODE ? PORT_CPU
                              : ((last_grant == PORT_DMA) ? PORT_CPU : PORT_DMA);

        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  state_next = ram_write ? DONE : CAPTURE;
            CAPTURE: state_next = DONE;
            DONE: begin
                state_next = IDLE;
                cpu.ack    = (grant == PORT_CPU);
                dma.ack    = (grant == PORT_DMA);
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if (winner == PORT_DMA) begin
            sel_we    = dma.we;
            sel_addr  = dma.addr;
            sel_be    = dma.be;
            sel_wdata = dma.wdata;
        end else begin
            sel_we    = cpu.we;
            sel_addr  = cpu.addr;
            sel_be    = cpu.be;
            sel_wdata = cpu.wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= PORT_CPU;
            last_grant     <= PORT_DMA;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= '0;
            ram_byteenable <= '0;
            ram_writedata  <= '0;
            cpu_rdata_q    <= '0;
            dma_rdata_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant          <= winner;
                        last_grant     <= winner;
                        ram_chipselect <= 1'b1;
                        ram_write      <= sel_we;
                        ram_address    <= sel_addr;
                        ram_byteenable <= sel_we ? sel_be : 2'b11;
                        ram_writedata  <= sel_wdata;
                    end
                end
                ACCESS: begin
                    ram_chipselect <= 1'b0;
                    ram_write      <= 1'b0;
                end
                CAPTURE: begin
                    // RAM output is unregistered: valid now, one cycle after ACCESS.
                    if (grant == PORT_CPU) cpu_rdata_q <= ram_readdata;
                    else                   dma_rdata_q <= ram_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Self-checking bench: two arbiters (round-robin and fixed priority), each in
// front of a behavioural RAM, with a scoreboard fed by the drivers.
`timescale 1ns/1ps

module tb_main_ram_arbiter;

    typedef struct packed { logic we; logic [15:0] data; } exp_t;
    typedef struct packed { logic p; int cyc; } ord_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // [m][p]: m = 0 round-robin DUT, 1 fixed DUT; p = 0 CPU, 1 DMA
    logic        t_req   [2][2];
    logic        t_we    [2][2];
    logic [15:0] t_addr  [2][2];
    logic [1:0]  t_be    [2][2];
    logic [15:0] t_wdata [2][2];
    logic        t_ack   [2][2];
    logic [15:0] t_rdata [2][2];

    logic        ram_cs [2], ram_wr [2], ram_clken [2], ram_rst [2], busy [2];
    logic [15:0] ram_addr [2], ram_wdata [2], ram_rdata [2];
    logic [1:0]  ram_be [2];

    logic [15:0] ref_mem [2][65536];
    exp_t        exp_q [2][2][$];
    ord_t        ord_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        main_ram_arbiter_if cpu_i ();
        main_ram_arbiter_if dma_i ();
        logic [15:0] mem [65536];
        logic [15:0] addr_q;

        assign cpu_i.req   = t_req[g][0];
        assign cpu_i.we    = t_we[g][0];
        assign cpu_i.addr  = t_addr[g][0];
        assign cpu_i.be    = t_be[g][0];
        assign cpu_i.wdata = t_wdata[g][0];
        assign dma_i.req   = t_req[g][1];
        assign dma_i.we    = t_we[g][1];
        assign dma_i.addr  = t_addr[g][1];
        assign dma_i.be    = t_be[g][1];
        assign dma_i.wdata = t_wdata[g][1];
        assign t_ack[g][0]   = cpu_i.ack;
        assign t_rdata[g][0] = cpu_i.rdata;
        assign t_ack[g][1]   = dma_i.ack;
        assign t_rdata[g][1] = dma_i.rdata;

        main_ram_arbiter #(.ARB_MODE(g == 1)) dut (
            .clk            (clk),
            .reset          (reset),
            .cpu            (cpu_i),
            .dma            (dma_i),
            .ram_chipselect (ram_cs[g]),
            .ram_write      (ram_wr[g]),
            .ram_address    (ram_addr[g]),
            .ram_byteenable (ram_be[g]),
            .ram_writedata  (ram_wdata[g]),
            .ram_readdata   (ram_rdata[g]),
            .ram_clken      (ram_clken[g]),
            .ram_reset_req  (ram_rst[g]),
            .busy           (busy[g])
        );

        // Behavioural SRAM: registered address/data, unregistered read port.
        initial begin
            addr_q = '0;
            for (int i = 0; i < 65536; i++) mem[i] = '0;
        end

        always @(posedge clk) begin
            if (ram_clken[g] && !ram_rst[g] && ram_cs[g]) begin
                if (ram_wr[g]) begin
                    if (ram_be[g][0]) mem[ram_addr[g]][7:0]  <= ram_wdata[g][7:0];
                    if (ram_be[g][1]) mem[ram_addr[g]][15:8] <= ram_wdata[g][15:8];
                end
                addr_q <= ram_addr[g];
            end
        end

        assign ram_rdata[g] = mem[addr_q];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one access and wait for its ack; the expected response is queued here.
    task automatic do_op(input int m, input int p, input logic w, input logic [15:0] a,
                         input logic [1:0] b, input logic [15:0] d, input bit keep,
                         output int lat);
        exp_t        e;
        logic [15:0] old;
        @(posedge clk); #1;
        t_req[m][p]   = 1'b1;
        t_we[m][p]    = w;
        t_addr[m][p]  = a;
        t_be[m][p]    = b;
        t_wdata[m][p] = d;
        old  = ref_mem[m][a];
        e.we   = w;
        e.data = old;
        if (w) ref_mem[m][a] = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
        exp_q[m][p].push_back(e);
        lat = 0;
        forever begin
            @(negedge clk);
            if (t_ack[m][p]) break;
            lat++;
            if (lat > 1000) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout m%0d p%0d addr %0h", m, p, a);
                break;
            end
        end
        if (!keep) begin
            @(posedge clk); #1;
            t_req[m][p] = 1'b0;
        end
    endtask

    task automatic rand_port(input int m, input int p, input int n);
        int          lat;
        logic        w;
        logic [15:0] a, d;
        logic [1:0]  b;
        bit          keep;
        for (int i = 0; i < n; i++) begin
            w    = 1'($urandom_range(0, 1));
            a    = {p[0], 11'h000, 4'($urandom_range(0, 15))};
            b    = 2'($urandom);
            d    = 16'($urandom);
            keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
            do_op(m, p, w, a, b, d, keep, lat);
            if (m == 0) check($sformatf("rr_latency_bound p%0d", p), lat <= 7, 1);
            if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input int m);
        check($sformatf("rst_busy m%0d", m),      busy[m], 0);
        check($sformatf("rst_cs m%0d", m),        ram_cs[m], 0);
        check($sformatf("rst_write m%0d", m),     ram_wr[m], 0);
        check($sformatf("rst_addr m%0d", m),      ram_addr[m], 0);
        check($sformatf("rst_be m%0d", m),        ram_be[m], 0);
        check($sformatf("rst_wdata m%0d", m),     ram_wdata[m], 0);
        check($sformatf("rst_cpu_ack m%0d", m),   t_ack[m][0], 0);
        check($sformatf("rst_dma_ack m%0d", m),   t_ack[m][1], 0);
        check($sformatf("rst_cpu_rdata m%0d", m), t_rdata[m][0], 0);
        check($sformatf("rst_dma_rdata m%0d", m), t_rdata[m][1], 0);
        check($sformatf("rst_clken m%0d", m),     ram_clken[m], 1);
    endtask

    // Monitor: pops the scoreboard on every ack and watches RAM-side strobes.
    initial begin
        logic prev_ack [2][2];
        logic prev_cs [2];
        exp_t e;
        ord_t o;
        for (int m = 0; m < 2; m++) begin
            prev_cs[m] = 1'b0;
            for (int p = 0; p < 2; p++) prev_ack[m][p] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (ram_cs[m]) begin
                    check($sformatf("cs_single_cycle m%0d", m), prev_cs[m], 0);
                    if (!ram_wr[m]) check($sformatf("read_be_forced m%0d", m), ram_be[m], 2'b11);
                end
                prev_cs[m] = ram_cs[m];
                for (int p = 0; p < 2; p++) begin
                    if (t_ack[m][p]) begin
                        check($sformatf("ack_single_cycle m%0d p%0d", m, p), prev_ack[m][p], 0);
                        if (exp_q[m][p].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_ack m%0d p%0d at cycle %0d", m, p, cyc);
                        end else begin
                            e = exp_q[m][p].pop_front();
                            if (!e.we)
                                check($sformatf("rdata m%0d p%0d", m, p), t_rdata[m][p], e.data);
                            o.p   = p[0];
                            o.cyc = cyc;
                            ord_q[m].push_back(o);
                        end
                    end
                    prev_ack[m][p] = t_ack[m][p];
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat, lat_c, lat_d;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                t_req[m][p] = 1'b0; t_we[m][p] = 1'b0; t_addr[m][p] = '0;
                t_be[m][p] = '0; t_wdata[m][p] = '0;
            end
            for (int i = 0; i < 65536; i++) ref_mem[m][i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check_reset_values(m);
            check($sformatf("ram_reset_req_high m%0d", m), ram_rst[m], 1);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("ram_reset_req_low", ram_rst[0], 0);

        // Single write/read, with latency from the request cycle.
        do_op(0, 0, 1'b1, 16'h1234, 2'b11, 16'hBEEF, 1'b0, lat);
        check("write_latency", lat, 2);
        do_op(0, 0, 1'b0, 16'h1234, 2'b00, 16'h0000, 1'b0, lat);
        check("read_latency", lat, 3);
        check("read_0x1234", t_rdata[0][0], 16'hBEEF);

        // Byte enables, including the all-zero case.
        do_op(0, 0, 1'b1, 16'h0010, 2'b11, 16'hAAAA, 1'b0, lat);
        do_op(0, 0, 1'b1, 16'h0010, 2'b01, 16'h1255, 1'b0, lat);
        do_op(0, 0, 1'b0, 16'h0010, 2'b11, 16'h0000, 1'b0, lat);
        check("byte_write_read", t_rdata[0][0], 16'hAA55);
        do_op(0, 0, 1'b1, 16'h0010, 2'b00, 16'hFFFF, 1'b0, lat);
        check("zero_be_write_latency", lat, 2);
        do_op(0, 0, 1'b0, 16'h0010, 2'b11, 16'h0000, 1'b0, lat);
        check("zero_be_read", t_rdata[0][0], 16'hAA55);

        // Address extremes from the DMA port.
        do_op(0, 1, 1'b1, 16'hFFFF, 2'b11, 16'h1111, 1'b0, lat);
        do_op(0, 1, 1'b1, 16'h0000, 2'b11, 16'h2222, 1'b0, lat);
        do_op(0, 1, 1'b0, 16'hFFFF, 2'b11, 16'h0000, 1'b0, lat);
        check("wrap_read_ffff", t_rdata[0][1], 16'h1111);
        do_op(0, 1, 1'b0, 16'h0000, 2'b11, 16'h0000, 1'b0, lat);
        check("wrap_read_0000", t_rdata[0][1], 16'h2222);
        check("cpu_rdata_held", t_rdata[0][0], 16'hAA55);

        // Reset during the ACCESS cycle of a write: no ack, memory untouched.
        @(posedge clk); #1;
        t_req[0][0] = 1'b1; t_we[0][0] = 1'b1; t_addr[0][0] = 16'h0100;
        t_be[0][0] = 2'b11; t_wdata[0][0] = 16'h5A5A;
        @(posedge clk); #1;
        reset = 1'b1;
        t_req[0][0] = 1'b0;
        @(negedge clk);
        check("midop_in_access_cs", ram_cs[0], 1);
        check("midop_reset_req", ram_rst[0], 1);
        @(negedge clk);
        check_reset_values(0);
        @(posedge clk); #1;
        reset = 1'b0;
        do_op(0, 0, 1'b0, 16'h0100, 2'b11, 16'h0000, 1'b0, lat);
        check("midop_read_0100", t_rdata[0][0], 16'h0000);

        // Round-robin with both ports holding requests.
        do_reset();
        ord_q[0].delete();
        fork
            begin
                do_op(0, 0, 1'b0, 16'h0001, 2'b11, 16'h0, 1'b1, lat_c);
                do_op(0, 0, 1'b0, 16'h0001, 2'b11, 16'h0, 1'b0, lat_c);
            end
            begin
                do_op(0, 1, 1'b0, 16'h0002, 2'b11, 16'h0, 1'b1, lat_d);
                do_op(0, 1, 1'b0, 16'h0002, 2'b11, 16'h0, 1'b0, lat_d);
            end
        join
        check("rr_ack_count", ord_q[0].size(), 4);
        for (int i = 0; i < ord_q[0].size() && i < 4; i++) begin
            check($sformatf("rr_order_%0d", i), ord_q[0][i].p, i % 2);
            if (i > 0) check($sformatf("rr_spacing_%0d", i), ord_q[0][i].cyc - ord_q[0][i-1].cyc, 4);
        end

        // Fixed priority: DMA waits until the CPU stops requesting.
        do_reset();
        ord_q[1].delete();
        fork
            begin
                do_op(1, 0, 1'b0, 16'h0001, 2'b11, 16'h0, 1'b1, lat_c);
                do_op(1, 0, 1'b0, 16'h0001, 2'b11, 16'h0, 1'b1, lat_c);
                do_op(1, 0, 1'b0, 16'h0001, 2'b11, 16'h0, 1'b0, lat_c);
            end
            do_op(1, 1, 1'b0, 16'h0002, 2'b11, 16'h0, 1'b0, lat_d);
        join
        check("fixed_ack_count", ord_q[1].size(), 4);
        for (int i = 0; i < ord_q[1].size() && i < 4; i++) begin
            check($sformatf("fixed_order_%0d", i), ord_q[1][i].p, (i == 3) ? 1 : 0);
            if (i > 0) check($sformatf("fixed_spacing_%0d", i), ord_q[1][i].cyc - ord_q[1][i-1].cyc, 4);
        end
        check("fixed_dma_latency", lat_d, 15);

        // Randomized traffic on both arbiters; ports use disjoint address windows.
        do_reset();
        fork
            rand_port(0, 0, 40);
            rand_port(0, 1, 40);
            rand_port(1, 0, 40);
            rand_port(1, 1, 40);
        join

        repeat (10) @(posedge clk);
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < 2; p++)
                check($sformatf("scoreboard_drained m%0d p%0d", m, p), exp_q[m][p].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
